// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory port and
// the arbiter. The arbiter uses the slave view; the requesters and the
// memory model use the master view.
interface mem_port_arbiter_if;
    // Instruction fetch side
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    // Data access side
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        err;
    // Single-port memory
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall, err,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall, err,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 16-bit memory between instruction fetch (IF) and
// data access (DM). Data wins by default; after STARVE_LIMIT consecutive data
// grants with a fetch waiting, the fetch is forced through. Each access holds
// the memory port for LATENCY cycles, then a one-cycle done pulse follows.
// Odd (misaligned) addresses skip the memory cycle and complete with err.
module mem_port_arbiter #(
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [3:0] WAIT_INIT  = 4'(LATENCY - 1);
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  streak;
    logic [3:0]  wait_cnt;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        lat_wr;
    logic        owner_dm;
    logic        err_flag;
    logic [15:0] if_rdata_q;
    logic [15:0] dm_rdata_q;

    logic        dm_win;
    logic        if_win;
    logic [15:0] grant_addr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Arbitration, next state and all bus outputs
    always_comb begin
        state_nxt  = state;
        dm_win     = 1'b0;
        if_win     = 1'b0;
        grant_addr = bus.if_addr;

        unique case (state)
            IDLE: begin
                // Data wins unless the fetch has been starved long enough
                if (bus.dm_req && !(bus.if_req && streak == STREAK_MAX))
                    dm_win = 1'b1;
                else if (bus.if_req)
                    if_win = 1'b1;
                grant_addr = dm_win ? bus.dm_addr : bus.if_addr;
                if (dm_win || if_win)
                    state_nxt = grant_addr[0] ? RESP : ACCESS;
            end
            ACCESS: if (wait_cnt == 4'd0) state_nxt = RESP;
            RESP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        bus.mem_en    = (state == ACCESS);
        bus.mem_wr    = (state == ACCESS) && lat_wr;
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
        bus.if_done   = (state == RESP) && !owner_dm;
        bus.dm_done   = (state == RESP) && owner_dm;
        bus.err       = (state == RESP) && err_flag;
        bus.if_rdata  = if_rdata_q;
        bus.dm_rdata  = dm_rdata_q;
        bus.if_stall  = bus.if_req && !bus.if_done;
        bus.dm_stall  = bus.dm_req && !bus.dm_done;
    end

    // Grant latching, starvation streak, wait counting and read capture
    always_ff @(posedge clk) begin
        if (rst) begin
            streak     <= 4'd0;
            wait_cnt   <= 4'd0;
            lat_addr   <= 16'd0;
            lat_wdata  <= 16'd0;
            lat_wr     <= 1'b0;
            owner_dm   <= 1'b0;
            err_flag   <= 1'b0;
            if_rdata_q <= 16'd0;
            dm_rdata_q <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dm_win || if_win) begin
                        lat_addr  <= grant_addr;
                        lat_wdata <= dm_win ? bus.dm_wdata : 16'd0;
                        lat_wr    <= dm_win && bus.dm_wr;
                        owner_dm  <= dm_win;
                        err_flag  <= grant_addr[0];
                        wait_cnt  <= WAIT_INIT;
                        if (dm_win && bus.if_req)
                            streak <= (streak < STREAK_MAX) ? streak + 4'd1 : streak;
                        else
                            streak <= 4'd0;
                        // A misaligned grant reports zero data in its done cycle
                        if (grant_addr[0]) begin
                            if (dm_win) dm_rdata_q <= 16'd0;
                            else        if_rdata_q <= 16'd0;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        if (!lat_wr) begin
                            if (owner_dm) dm_rdata_q <= bus.mem_rdata;
                            else          if_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single-request vectors from a table,
// then hand-written sequences for contention, starvation, reset during an
// access and back-to-back fetches with single-cycle latency.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int both_done_a = 0;
    int both_done_b = 0;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];

    mem_port_arbiter_if bus_a();
    mem_port_arbiter_if bus_b();

    mem_port_arbiter #(.LATENCY(2), .STARVE_LIMIT(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mem_port_arbiter #(.LATENCY(1), .STARVE_LIMIT(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Memory models: combinational read, write on the clock edge
    assign bus_a.mem_rdata = mem_a[bus_a.mem_addr[8:1]];
    assign bus_b.mem_rdata = mem_b[bus_b.mem_addr[8:1]];

    always @(posedge clk) begin
        if (bus_a.mem_en && bus_a.mem_wr) mem_a[bus_a.mem_addr[8:1]] <= bus_a.mem_wdata;
        if (bus_b.mem_en && bus_b.mem_wr) mem_b[bus_b.mem_addr[8:1]] <= bus_b.mem_wdata;
    end

    always @(negedge clk) begin
        if (bus_a.if_done && bus_a.dm_done) both_done_a++;
        if (bus_b.if_done && bus_b.dm_done) both_done_b++;
    end

    typedef struct {
        bit          dm;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        bit          exp_err;
        int          exp_cyc;
        int          exp_en;
        int          exp_wr;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one request on bus_a from IDLE and follow it to its done pulse
    task automatic run_req(input vec_t v, output int cyc, output int en_c, output int wr_c,
                           output logic [15:0] rd, output logic e, output logic st,
                           output bit to);
        @(posedge clk); #1;
        if (v.dm) begin
            bus_a.dm_req   = 1'b1;
            bus_a.dm_wr    = v.wr;
            bus_a.dm_addr  = v.addr;
            bus_a.dm_wdata = v.wdata;
        end else begin
            bus_a.if_req  = 1'b1;
            bus_a.if_addr = v.addr;
        end
        cyc = 0; en_c = 0; wr_c = 0; rd = 16'd0; e = 1'b0; st = 1'b1; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus_a.mem_en) en_c++;
            if (bus_a.mem_wr) wr_c++;
            if ((v.dm && bus_a.dm_done) || (!v.dm && bus_a.if_done)) begin
                rd = v.dm ? bus_a.dm_rdata : bus_a.if_rdata;
                st = v.dm ? bus_a.dm_stall : bus_a.if_stall;
                e  = bus_a.err;
                to = 1'b0;
                break;
            end
        end
        bus_a.dm_req = 1'b0;
        bus_a.if_req = 1'b0;
    endtask

    initial begin
        int cyc, en_c, wr_c, ev, dm_cyc, if_cyc, stall_low, done_n;
        logic [15:0] rd;
        logic e, st, loser_stall;
        bit to;
        bit exp_is_if [10];

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'h0;
            mem_b[i] = 16'h0;
        end
        mem_a[0] = 16'hCAFE;  mem_a[1] = 16'h5A5A;  mem_a[8] = 16'hBEEF;
        mem_b[0] = 16'h1111;  mem_b[1] = 16'h2222;

        vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 3, 2, 0};
        vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'hBEEF, 1'b0, 3, 2, 2};
        vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hCAFE, 1'b0, 3, 2, 0};
        vecs[3] = '{1'b1, 1'b0, 16'h0031, 16'h0000, 16'h0000, 1'b1, 1, 0, 0};
        vecs[4] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b1, 1, 0, 0};
        vecs[5] = '{1'b0, 1'b0, 16'h0002, 16'h0000, 16'h5A5A, 1'b0, 3, 2, 0};
        vecs[6] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0, 3, 2, 0};

        bus_a.if_req = 0; bus_a.if_addr = 0; bus_a.dm_req = 0; bus_a.dm_wr = 0;
        bus_a.dm_addr = 0; bus_a.dm_wdata = 0;
        bus_b.if_req = 0; bus_b.if_addr = 0; bus_b.dm_req = 0; bus_b.dm_wr = 0;
        bus_b.dm_addr = 0; bus_b.dm_wdata = 0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", 16'({bus_a.if_done, bus_a.dm_done, bus_a.err}), 16'h0);
        check("rst_mem_ctl", 16'({bus_a.mem_en, bus_a.mem_wr}), 16'h0);
        check("rst_mem_addr", bus_a.mem_addr, 16'h0);
        check("rst_mem_wdata", bus_a.mem_wdata, 16'h0);
        check("rst_rdata", bus_a.if_rdata | bus_a.dm_rdata, 16'h0);
        check("rst_stall", 16'({bus_a.if_stall, bus_a.dm_stall}), 16'h0);
        rst = 1'b0;

        // Table-driven single requests
        for (int k = 0; k < 7; k++) begin
            run_req(vecs[k], cyc, en_c, wr_c, rd, e, st, to);
            check($sformatf("v%0d_timeout", k), 16'(to), 16'h0);
            check($sformatf("v%0d_latency", k), 16'(cyc), 16'(vecs[k].exp_cyc));
            check($sformatf("v%0d_mem_en_cycles", k), 16'(en_c), 16'(vecs[k].exp_en));
            check($sformatf("v%0d_mem_wr_cycles", k), 16'(wr_c), 16'(vecs[k].exp_wr));
            check($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rdata);
            check($sformatf("v%0d_err", k), 16'(e), 16'(vecs[k].exp_err));
            check($sformatf("v%0d_stall_at_done", k), 16'(st), 16'h0);
            if (vecs[k].wr)
                check($sformatf("v%0d_mem_written", k), mem_a[vecs[k].addr[8:1]], vecs[k].wdata);
        end

        // IF and DM together: DM write first, then IF four cycles later
        mem_a[16] = 16'h0;
        @(posedge clk); #1;
        bus_a.if_req = 1; bus_a.if_addr = 16'h0000;
        bus_a.dm_req = 1; bus_a.dm_wr = 1; bus_a.dm_addr = 16'h0020; bus_a.dm_wdata = 16'h1234;
        dm_cyc = -1; if_cyc = -1; wr_c = 0; loser_stall = 1'b0; rd = 16'h0;
        for (int c = 1; c <= 30 && if_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (bus_a.mem_wr) wr_c++;
            if (bus_a.dm_done) begin
                dm_cyc = c; loser_stall = bus_a.if_stall; bus_a.dm_req = 0;
            end
            if (bus_a.if_done) begin
                if_cyc = c; rd = bus_a.if_rdata; bus_a.if_req = 0;
            end
        end
        bus_a.dm_wr = 0;
        check("both_dm_done_cycle", 16'(dm_cyc), 16'd3);
        check("both_if_done_cycle", 16'(if_cyc), 16'd7);
        check("both_mem_wr_cycles", 16'(wr_c), 16'd2);
        check("both_mem_written", mem_a[16], 16'h1234);
        check("both_if_stall_while_dm_done", 16'(loser_stall), 16'h1);
        check("both_if_rdata", rd, 16'hCAFE);

        // Starvation: both held high, IF forced through every fifth grant
        exp_is_if = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        @(posedge clk); #1;
        bus_a.dm_req = 1; bus_a.dm_wr = 0; bus_a.dm_addr = 16'h0010;
        bus_a.if_req = 1; bus_a.if_addr = 16'h0002;
        ev = 0;
        for (int c = 0; c < 80 && ev < 10; c++) begin
            @(posedge clk); #1;
            if (bus_a.dm_done || bus_a.if_done) begin
                check($sformatf("starve_ev%0d_is_if", ev), 16'(bus_a.if_done), 16'(exp_is_if[ev]));
                ev++;
            end
        end
        bus_a.dm_req = 0; bus_a.if_req = 0;
        check("starve_event_count", 16'(ev), 16'd10);

        // Reset during the second ACCESS cycle of a fetch
        @(posedge clk); #1;
        bus_a.if_req = 1; bus_a.if_addr = 16'h0002;
        @(posedge clk); #1;
        check("rstmid_access1_en", 16'(bus_a.mem_en), 16'h1);
        @(posedge clk); #1;
        rst = 1; bus_a.if_req = 0;
        @(posedge clk); #1;
        check("rstmid_no_done", 16'({bus_a.if_done, bus_a.dm_done, bus_a.err}), 16'h0);
        check("rstmid_mem_ctl", 16'({bus_a.mem_en, bus_a.mem_wr}), 16'h0);
        check("rstmid_mem_addr", bus_a.mem_addr, 16'h0);
        check("rstmid_if_rdata", bus_a.if_rdata, 16'h0);
        rst = 0;
        @(posedge clk); #1;
        check("rstmid_still_no_done", 16'(bus_a.if_done), 16'h0);
        run_req(vecs[5], cyc, en_c, wr_c, rd, e, st, to);
        check("rstmid_fresh_timeout", 16'(to), 16'h0);
        check("rstmid_fresh_latency", 16'(cyc), 16'd3);
        check("rstmid_fresh_rdata", rd, 16'h5A5A);

        // LATENCY=1: back-to-back fetches, done every three cycles
        @(posedge clk); #1;
        bus_b.if_req = 1; bus_b.if_addr = 16'h0000;
        done_n = 0; stall_low = 0;
        for (int c = 1; c <= 20 && done_n < 2; c++) begin
            @(posedge clk); #1;
            if (!bus_b.if_stall) stall_low++;
            if (bus_b.if_done) begin
                if (done_n == 0) begin
                    check("lat1_first_done_cycle", 16'(c), 16'd2);
                    check("lat1_first_rdata", bus_b.if_rdata, 16'h1111);
                    bus_b.if_addr = 16'h0002;
                end else begin
                    check("lat1_second_done_cycle", 16'(c), 16'd5);
                    check("lat1_second_rdata", bus_b.if_rdata, 16'h2222);
                end
                done_n++;
            end
        end
        bus_b.if_req = 0;
        check("lat1_done_count", 16'(done_n), 16'd2);
        check("lat1_stall_low_cycles", 16'(stall_low), 16'd2);

        check("a_never_both_done", 16'(both_done_a), 16'd0);
        check("b_never_both_done", 16'(both_done_b), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares one single-port, 16-bit, byte-addressed, word-aligned memory between two requesters: instruction fetch (IF) and data access (DM).
- The memory reads combinationally and writes on the clock edge; read and write in the same cycle are not allowed.
- The block serialises requests and adds a configurable number of wait states to model slow memory.
- It returns read data and done/stall handshakes to the pipeline, and flags misaligned addresses.

Parameters:
- LATENCY, 2: cycles the memory port is driven per access; legal range 1..15.
- STARVE_LIMIT, 4: consecutive DM grants allowed while IF is waiting before IF is forced through; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  16  fetch byte address
- if_rdata  out  16  fetch data; valid while if_done=1, held until the next IF completion
- if_done  out  1  one-cycle completion pulse for IF
- if_stall  out  1  equals if_req & ~if_done
- dm_req  in  1  data request; held high until dm_done
- dm_wr  in  1  1 = write, 0 = read
- dm_addr  in  16  data byte address
- dm_wdata  in  16  write data
- dm_rdata  out  16  load data; valid while dm_done=1, held until the next DM completion
- dm_done  out  1  one-cycle completion pulse for DM
- dm_stall  out  1  equals dm_req & ~dm_done
- err  out  1  pulses with done when the granted address has addr[0]=1
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write strobe
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data (combinational from mem_addr)

Behaviour:
- Reset is synchronous, active-high; clock is clk.
- On reset: state IDLE, streak counter 0, wait counter 0, latched address/wdata/wr 0, if_rdata = dm_rdata = 0.
  - All outputs are 0 from the cycle after the rst edge: done, err, mem_en, mem_wr, mem_addr, mem_wdata, and both stalls unless the matching req is high.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - On a clk edge with any req high: pick the winner; latch its addr, wdata and wr (IF is always read); record the owner.
  - Aligned address: go to ACCESS with wait counter = LATENCY-1.
  - addr[0]=1: go directly to RESP with error flag set; no memory cycle is issued.
- Arbitration:
  - DM beats IF, unless streak == STARVE_LIMIT and if_req=1; then IF wins and streak clears.
  - A DM grant with if_req=1 increments streak, saturating at STARVE_LIMIT.
  - A DM grant with if_req=0, or any IF grant, clears streak.
- ACCESS:
  - mem_en=1; mem_addr and mem_wdata are the latched values; mem_wr = latched wr.
  - Writes repeat the same data on every ACCESS cycle, which is harmless.
  - Wait counter decrements each cycle. In the cycle it reads 0, mem_rdata is captured into the owner's rdata register (reads only); next state is RESP.
- RESP:
  - The owner's done=1 for exactly one cycle; err=1 if the error flag is set.
  - Error: owner rdata is forced to 0. Write: owner rdata is left unchanged.
  - Requests are not sampled; next state is IDLE.
  - A req still high in the following IDLE cycle is treated as a new request.
- Outside ACCESS: mem_en=0 and mem_wr=0; mem_addr and mem_wdata hold the last latched values.
- Latency: req first seen at edge T; ACCESS occupies cycles T+1..T+LATENCY; done in cycle T+LATENCY+1. Service period is LATENCY+2 cycles per access.
- Simultaneous if_req and dm_req: exactly one grant per IDLE; the loser stays stalled, and its stall stays high.
- A request input that changes while not granted has no effect; inputs are sampled only at the grant edge.
- rst asserted mid-ACCESS: the next edge returns to IDLE, mem_en drops, and no done is issued. Writes already clocked into memory remain.
- The two done signals are never high together.

Test Plan:
- LATENCY=2; DM read 0x0010 with memory word 0xBEEF:
  - mem_en high for exactly 2 cycles at addr 0x0010.
  - dm_done pulses one cycle later with dm_rdata=0xBEEF; dm_stall low in that cycle.
- IF and DM request together from IDLE (IF 0x0000, DM write 0x0020 with data 0x1234):
  - DM served first: mem_wr=1 for 2 cycles and memory[0x20]=0x1234.
  - IF is then served, with if_done 4 cycles after dm_done.
- STARVE_LIMIT=4; dm_req held high continuously, if_req high:
  - Exactly 4 dm_done pulses, then an if_done, then DM resumes.
  - Streak resets after the IF grant.
- DM read with dm_addr=0x0031:
  - No mem_en pulse.
  - dm_done and err both pulse in the cycle after grant, with dm_rdata=0.
- rst pulsed during the second ACCESS cycle of an IF fetch:
  - No if_done; all outputs 0 the next cycle.
  - A fresh if_req then completes normally.
- LATENCY=1 back-to-back IF fetches at 0x0000 and 0x0002:
  - if_done every 3 cycles with the correct words.
  - if_stall low only in the done cycles.
